// File: rtl/i2c_slave_regs.sv
// i2c_slave_regs: oversampled I2C target with a 16 x 8 register file, byte pointer and auto-increment.
// SCL/SDA are synchronized and glitch-filtered on clk_25; every register write is mirrored on wr_stb.
module i2c_slave_regs #(
    parameter logic [6:0] SLV_ADDR = 7'h50,
    parameter int         FILT_LEN = 3
) (
    input  logic       clk_25,
    input  logic       reset,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_out,
    output logic       wr_stb,
    output logic [3:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       busy
);
    localparam int CW = (FILT_LEN < 2) ? 1 : $clog2(FILT_LEN);
    localparam logic [CW-1:0] CNT_MAX = CW'(FILT_LEN - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1'b1);

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        RX_ADDR  = 4'd1,
        ACK_ADDR = 4'd2,
        RX_PTR   = 4'd3,
        ACK_PTR  = 4'd4,
        RX_DATA  = 4'd5,
        ACK_DATA = 4'd6,
        TX_DATA  = 4'd7,
        RX_MACK  = 4'd8,
        IGNORE   = 4'd9
    } state_t;

    // index 0 = SCL, index 1 = SDA
    logic [1:0]         sync1_r, sync2_r, filt_r, filt_d_r;
    logic [1:0][CW-1:0] cnt_r;

    logic       scl_rise_s, scl_fall_s, start_s, stop_s;
    logic       rx_state_s, byte_done_s, write_s;
    logic [7:0] rx_next_s, rd_byte_s;

    state_t     state_r, state_nxt;
    logic [2:0] bit_cnt_r, bit_cnt_nxt;
    logic [6:0] rx_byte_r, rx_byte_nxt;
    logic [7:0] tx_byte_r, tx_byte_nxt;
    logic [3:0] ptr_r, ptr_nxt;
    logic       phase_r, phase_nxt;
    logic       sda_out_r, sda_out_nxt;
    logic       busy_r, busy_nxt;
    logic       wr_stb_r, wr_stb_nxt;
    logic [3:0] wr_addr_r, wr_addr_nxt;
    logic [7:0] wr_data_r, wr_data_nxt;
    logic [7:0] regs_r [16];

    // Two-flop synchronizer followed by a run-length glitch filter on each line
    always_ff @(posedge clk_25 or posedge reset) begin
        if (reset) begin
            sync1_r  <= 2'b11;
            sync2_r  <= 2'b11;
            filt_r   <= 2'b11;
            filt_d_r <= 2'b11;
            cnt_r    <= '0;
        end else begin
            sync1_r  <= {sda_in, scl_in};
            sync2_r  <= sync1_r;
            filt_d_r <= filt_r;
            for (int i = 0; i < 2; i++) begin
                if (sync2_r[i] == filt_r[i]) begin
                    cnt_r[i] <= '0;
                end else if (cnt_r[i] == CNT_MAX) begin
                    filt_r[i] <= sync2_r[i];
                    cnt_r[i]  <= '0;
                end else begin
                    cnt_r[i] <= cnt_r[i] + CNT_ONE;
                end
            end
        end
    end

    assign scl_rise_s  = filt_r[0] & ~filt_d_r[0];
    assign scl_fall_s  = ~filt_r[0] & filt_d_r[0];
    assign start_s     = ~filt_r[1] & filt_d_r[1] & filt_r[0];
    assign stop_s      = filt_r[1] & ~filt_d_r[1] & filt_r[0];
    assign rx_next_s   = {rx_byte_r, filt_r[1]};
    assign rd_byte_s   = regs_r[ptr_r];
    assign rx_state_s  = (state_r == RX_ADDR) || (state_r == RX_PTR) || (state_r == RX_DATA);
    assign byte_done_s = scl_rise_s && rx_state_s && (bit_cnt_r == 3'd7);
    assign write_s     = byte_done_s && (state_r == RX_DATA);

    // Next-state and output logic; START/STOP override edge-driven moves but not a completing write
    always_comb begin
        state_nxt   = state_r;
        phase_nxt   = phase_r;
        tx_byte_nxt = tx_byte_r;
        sda_out_nxt = sda_out_r;
        busy_nxt    = busy_r;
        wr_stb_nxt  = write_s;

        if (scl_rise_s && (rx_state_s || (state_r == TX_DATA))) begin
            bit_cnt_nxt = bit_cnt_r + 3'd1;
        end else begin
            bit_cnt_nxt = bit_cnt_r;
        end

        if (scl_rise_s && rx_state_s) begin
            rx_byte_nxt = rx_next_s[6:0];
        end else begin
            rx_byte_nxt = rx_byte_r;
        end

        if (write_s) begin
            wr_addr_nxt = ptr_r;
            wr_data_nxt = rx_next_s;
            ptr_nxt     = ptr_r + 4'd1;
        end else begin
            wr_addr_nxt = wr_addr_r;
            wr_data_nxt = wr_data_r;
            ptr_nxt     = ptr_r;
        end

        if (start_s) begin
            state_nxt   = RX_ADDR;
            bit_cnt_nxt = 3'd0;
            sda_out_nxt = 1'b1;
            busy_nxt    = 1'b0;
            phase_nxt   = 1'b0;
        end else if (stop_s) begin
            state_nxt   = IDLE;
            sda_out_nxt = 1'b1;
            busy_nxt    = 1'b0;
            phase_nxt   = 1'b0;
        end else begin
            case (state_r)
                RX_ADDR: begin
                    if (byte_done_s && (rx_next_s[7:1] == SLV_ADDR)) begin
                        state_nxt = ACK_ADDR;
                        busy_nxt  = 1'b1;
                        phase_nxt = 1'b0;
                    end else if (byte_done_s) begin
                        state_nxt = IGNORE;
                    end else begin
                        state_nxt = RX_ADDR;
                    end
                end
                RX_PTR: begin
                    if (byte_done_s) begin
                        ptr_nxt   = rx_next_s[3:0];
                        state_nxt = ACK_PTR;
                        phase_nxt = 1'b0;
                    end else begin
                        state_nxt = RX_PTR;
                    end
                end
                RX_DATA: begin
                    if (byte_done_s) begin
                        state_nxt = ACK_DATA;
                        phase_nxt = 1'b0;
                    end else begin
                        state_nxt = RX_DATA;
                    end
                end
                // phase 0: waiting for the fall after bit 8; phase 1: ACK driven, waiting for the 9th fall
                ACK_ADDR, ACK_PTR, ACK_DATA: begin
                    if (!scl_fall_s) begin
                        state_nxt = state_r;
                    end else if (!phase_r) begin
                        sda_out_nxt = 1'b0;
                        phase_nxt   = 1'b1;
                    end else begin
                        phase_nxt   = 1'b0;
                        bit_cnt_nxt = 3'd0;
                        if ((state_r == ACK_ADDR) && rx_byte_r[0]) begin
                            state_nxt   = TX_DATA;
                            sda_out_nxt = rd_byte_s[7];
                            tx_byte_nxt = {rd_byte_s[6:0], 1'b1};
                        end else if (state_r == ACK_ADDR) begin
                            state_nxt   = RX_PTR;
                            sda_out_nxt = 1'b1;
                        end else begin
                            state_nxt   = RX_DATA;
                            sda_out_nxt = 1'b1;
                        end
                    end
                end
                TX_DATA: begin
                    if (scl_rise_s) begin
                        state_nxt = TX_DATA;
                    end else if (scl_fall_s && (bit_cnt_r == 3'd0)) begin
                        sda_out_nxt = 1'b1;
                        ptr_nxt     = ptr_r + 4'd1;
                        state_nxt   = RX_MACK;
                        phase_nxt   = 1'b0;
                    end else if (scl_fall_s) begin
                        sda_out_nxt = tx_byte_r[7];
                        tx_byte_nxt = {tx_byte_r[6:0], 1'b1};
                    end else begin
                        state_nxt = TX_DATA;
                    end
                end
                // phase 1 marks a master ACK seen; the next byte starts at the following fall
                RX_MACK: begin
                    if (scl_rise_s && filt_r[1]) begin
                        state_nxt   = IGNORE;
                        sda_out_nxt = 1'b1;
                    end else if (scl_rise_s) begin
                        phase_nxt = 1'b1;
                    end else if (scl_fall_s && phase_r) begin
                        state_nxt   = TX_DATA;
                        bit_cnt_nxt = 3'd0;
                        phase_nxt   = 1'b0;
                        sda_out_nxt = rd_byte_s[7];
                        tx_byte_nxt = {rd_byte_s[6:0], 1'b1};
                    end else begin
                        state_nxt = RX_MACK;
                    end
                end
                IDLE, IGNORE: begin
                    state_nxt = state_r;
                end
                default: begin
                    state_nxt   = IDLE;
                    sda_out_nxt = 1'b1;
                    busy_nxt    = 1'b0;
                end
            endcase
        end
    end

    // FSM, datapath and registered outputs
    always_ff @(posedge clk_25 or posedge reset) begin
        if (reset) begin
            state_r   <= IDLE;
            bit_cnt_r <= 3'd0;
            rx_byte_r <= 7'h00;
            tx_byte_r <= 8'hFF;
            ptr_r     <= 4'd0;
            phase_r   <= 1'b0;
            sda_out_r <= 1'b1;
            busy_r    <= 1'b0;
            wr_stb_r  <= 1'b0;
            wr_addr_r <= 4'd0;
            wr_data_r <= 8'h00;
        end else begin
            state_r   <= state_nxt;
            bit_cnt_r <= bit_cnt_nxt;
            rx_byte_r <= rx_byte_nxt;
            tx_byte_r <= tx_byte_nxt;
            ptr_r     <= ptr_nxt;
            phase_r   <= phase_nxt;
            sda_out_r <= sda_out_nxt;
            busy_r    <= busy_nxt;
            wr_stb_r  <= wr_stb_nxt;
            wr_addr_r <= wr_addr_nxt;
            wr_data_r <= wr_data_nxt;
        end
    end

    // Register file
    always_ff @(posedge clk_25 or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) begin
                regs_r[i] <= 8'h00;
            end
        end else if (write_s) begin
            regs_r[ptr_r] <= rx_next_s;
        end
    end

    assign sda_out = sda_out_r;
    assign busy    = busy_r;
    assign wr_stb  = wr_stb_r;
    assign wr_addr = wr_addr_r;
    assign wr_data = wr_data_r;

endmodule

// File: tb/tb_i2c_slave_regs.sv
// tb_i2c_slave_regs: bus-level I2C master driving i2c_slave_regs, checked against an array model
// of the register file with a modulo-16 pointer.
module tb_i2c_slave_regs;
    localparam int         Q    = 10;
    localparam logic [6:0] ADDR = 7'h50;

    logic       clk_25 = 1'b0;
    logic       reset;
    logic       scl_m, sda_m, sda_in;
    logic       sda_out, wr_stb, busy;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          low_cnt  = 0;
    logic [7:0]  model_regs [16];
    logic [11:0] ev_q [$];
    logic [11:0] exp_q [$];
    logic [7:0]  tx_q [$];

    always #20 clk_25 = ~clk_25;

    // open-drain bus: master and slave both pull low
    assign sda_in = sda_m & sda_out;

    i2c_slave_regs #(.SLV_ADDR(ADDR), .FILT_LEN(3)) dut (
        .clk_25  (clk_25),
        .reset   (reset),
        .scl_in  (scl_m),
        .sda_in  (sda_in),
        .sda_out (sda_out),
        .wr_stb  (wr_stb),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .busy    (busy)
    );

    always @(negedge clk_25) begin
        if (wr_stb === 1'b1) ev_q.push_back({wr_addr, wr_data});
        if (sda_out === 1'b0) low_cnt++;
    end

    initial begin
        repeat (90000) @(posedge clk_25);
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk_25);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; wait_cyc(Q);
        scl_m = 1'b1; wait_cyc(Q);
        sda_m = 1'b0; wait_cyc(Q);
        scl_m = 1'b0; wait_cyc(Q);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wait_cyc(Q);
        scl_m = 1'b1; wait_cyc(Q);
        sda_m = 1'b1; wait_cyc(3 * Q);
    endtask

    // glitch_bit selects a bit (0 = MSB) whose high phase gets a 2-cycle low pulse on SCL
    task automatic send_bits(input logic [7:0] b, input int glitch_bit);
        for (int i = 7; i >= 0; i--) begin
            sda_m = b[i]; wait_cyc(Q);
            scl_m = 1'b1;
            if ((7 - i) == glitch_bit) begin
                wait_cyc(8);
                scl_m = 1'b0; wait_cyc(2);
                scl_m = 1'b1; wait_cyc(2 * Q - 10);
            end else begin
                wait_cyc(2 * Q);
            end
            scl_m = 1'b0; wait_cyc(Q);
        end
    endtask

    task automatic write_byte(input logic [7:0] b, input int glitch_bit, output logic ack);
        send_bits(b, glitch_bit);
        sda_m = 1'b1; wait_cyc(Q);
        ack = ~sda_out;
        scl_m = 1'b1; wait_cyc(2 * Q);
        scl_m = 1'b0; wait_cyc(Q);
    endtask

    task automatic read_byte(input logic last, output logic [7:0] b, output logic rel);
        for (int i = 7; i >= 0; i--) begin
            sda_m = 1'b1; wait_cyc(Q);
            scl_m = 1'b1; wait_cyc(Q);
            b[i] = sda_in; wait_cyc(Q);
            scl_m = 1'b0; wait_cyc(Q);
        end
        sda_m = last; wait_cyc(Q);
        rel = sda_out;
        scl_m = 1'b1; wait_cyc(2 * Q);
        scl_m = 1'b0; wait_cyc(Q);
        sda_m = 1'b1;
    endtask

    task automatic do_write(input logic [7:0] p, input int glitch_bit);
        logic       ack;
        logic [3:0] mp;
        int         base;
        base = ev_q.size();
        exp_q.delete();
        mp = p[3:0];
        i2c_start();
        write_byte({ADDR, 1'b0}, -1, ack);
        check("w_addr_ack", 32'(ack), 32'h1);
        check("busy_on", 32'(busy), 32'h1);
        write_byte(p, -1, ack);
        check("w_ptr_ack", 32'(ack), 32'h1);
        for (int k = 0; k < tx_q.size(); k++) begin
            write_byte(tx_q[k], (k == 0) ? glitch_bit : -1, ack);
            check("w_data_ack", 32'(ack), 32'h1);
            model_regs[mp] = tx_q[k];
            exp_q.push_back({mp, tx_q[k]});
            mp = mp + 4'd1;
        end
        i2c_stop();
        check("busy_off", 32'(busy), 32'h0);
        check("wr_count", 32'(ev_q.size() - base), 32'(exp_q.size()));
        for (int k = 0; k < exp_q.size(); k++) begin
            if (base + k < ev_q.size()) check("wr_event", 32'(ev_q[base + k]), 32'(exp_q[k]));
        end
    endtask

    task automatic do_read(input logic [7:0] p, input int n);
        logic       ack, rel;
        logic [7:0] b;
        logic [3:0] mp;
        mp = p[3:0];
        i2c_start();
        write_byte({ADDR, 1'b0}, -1, ack);
        check("r_waddr_ack", 32'(ack), 32'h1);
        write_byte(p, -1, ack);
        check("r_ptr_ack", 32'(ack), 32'h1);
        i2c_start();
        write_byte({ADDR, 1'b1}, -1, ack);
        check("r_addr_ack", 32'(ack), 32'h1);
        for (int k = 0; k < n; k++) begin
            read_byte(k == n - 1, b, rel);
            check("r_data", 32'(b), 32'(model_regs[mp]));
            check("r_mack_released", 32'(rel), 32'h1);
            mp = mp + 4'd1;
        end
        check("r_nack_released", 32'(sda_out), 32'h1);
        i2c_stop();
    endtask

    initial begin
        logic       ack;
        logic [7:0] p;
        int         n, base, low0;

        for (int i = 0; i < 16; i++) model_regs[i] = 8'h00;
        reset = 1'b1;
        scl_m = 1'b1;
        sda_m = 1'b1;
        wait_cyc(4);
        check("rst_sda_out", 32'(sda_out), 32'h1);
        check("rst_wr_stb", 32'(wr_stb), 32'h0);
        check("rst_wr_addr", 32'(wr_addr), 32'h0);
        check("rst_wr_data", 32'(wr_data), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        reset = 1'b0;
        wait_cyc(2 * Q);

        // write then read back across a repeated START
        tx_q = '{8'hA5, 8'h5A};
        do_write(8'h03, -1);
        do_read(8'h03, 2);

        // address mismatch
        base = ev_q.size();
        low0 = low_cnt;
        i2c_start();
        write_byte(8'hA2, -1, ack);
        check("mm_addr_nack", 32'(ack), 32'h0);
        check("mm_busy", 32'(busy), 32'h0);
        write_byte(8'h11, -1, ack);
        check("mm_data_nack", 32'(ack), 32'h0);
        i2c_stop();
        check("mm_sda_low_cycles", 32'(low_cnt - low0), 32'h0);
        check("mm_no_wr", 32'(ev_q.size() - base), 32'h0);
        check("mm_busy_end", 32'(busy), 32'h0);

        // pointer wrap 15 -> 0
        tx_q = '{8'h11, 8'h22};
        do_write(8'h0F, -1);
        do_read(8'h0F, 2);

        // SCL glitch inside the first data byte
        tx_q = '{8'h3C};
        do_write(8'h07, 3);
        do_read(8'h07, 1);

        // randomized writes with junk in the pointer's upper nibble, read back one past the end
        for (int t = 0; t < 6; t++) begin
            p = 8'($urandom);
            n = int'($urandom_range(1, 4));
            tx_q.delete();
            for (int j = 0; j < n; j++) tx_q.push_back(8'($urandom));
            do_write(p, -1);
            do_read(p, n + 1);
        end

        // reset while the address ACK is being driven
        tx_q = '{8'hC3};
        do_write(8'h03, -1);
        i2c_start();
        send_bits({ADDR, 1'b0}, -1);
        sda_m = 1'b1;
        wait_cyc(Q);
        check("ack_pre_reset", 32'(sda_out), 32'h0);
        #3 reset = 1'b1;
        #1;
        check("rst_sda_async", 32'(sda_out), 32'h1);
        check("rst_busy_async", 32'(busy), 32'h0);
        wait_cyc(2);
        scl_m = 1'b1;
        sda_m = 1'b1;
        wait_cyc(1);
        reset = 1'b0;
        for (int i = 0; i < 16; i++) model_regs[i] = 8'h00;
        wait_cyc(4 * Q);
        do_read(8'h03, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/i2c_slave_regs.md
Name: i2c_slave_regs

Overview:
- I2C target that consumes the slave-side bus produced by the repeater.
  - Inputs: the forwarded SCL and SDA.
  - Output: the slave's SDA drive value, which the repeater reflects back onto the master bus.
- Implements a 7-bit-addressed 16 x 8 register file with a byte pointer and auto-increment.
- Everything is oversampled on clk_25: filter, synchronizer, START/STOP detection, bit FSM.
- Exposes a write-strobe side channel so system logic sees every register update.

Parameters:
SLV_ADDR, 7'h50, 7-bit I2C target address
FILT_LEN, 3, number of consecutive equal synchronized samples required before a filtered SCL/SDA level changes (min 1)

Ports:
clk_25  input  1  system clock, 25 MHz
reset  input  1  asynchronous, active-high reset
scl_in  input  1  slave-side SCL from repeater
sda_in  input  1  slave-side SDA from repeater
sda_out  output  1  slave SDA drive: 0 = pull low, 1 = release
wr_stb  output  1  one-cycle pulse per register written over I2C
wr_addr  output  4  register index of current write
wr_data  output  8  data written
busy  output  1  high from address match until STOP or START

Behaviour:
- Reset is asynchronous, active-high, and clears all state:
  - sda_out=1, wr_stb=0, wr_addr=0, wr_data=0, busy=0.
  - All 16 registers = 8'h00, pointer = 0, FSM = IDLE.
  - Filtered SCL and SDA both reset to 1.
- Input path, per line:
  - 2-FF synchronizer.
  - Glitch filter: the filtered level changes only after FILT_LEN consecutive synchronized samples differ from it.
  - Edge detect on the filtered levels.
  - Worst-case latency from pin to edge event = 2 + FILT_LEN cycles.
- Bus condition detection:
  - START: filtered SDA falls while filtered SCL = 1.
  - STOP: filtered SDA rises while filtered SCL = 1.
  - SDA data is sampled on filtered SCL rising edge.
  - sda_out changes only in the cycle after a filtered SCL falling edge.
- FSM states: IDLE, RX_ADDR, ACK_ADDR, RX_PTR, ACK_PTR, RX_DATA, ACK_DATA, TX_DATA, RX_MACK, IGNORE.
- START in any state:
  - Go to RX_ADDR, bit count = 0, sda_out = 1.
  - Pointer is retained across a repeated START.
- STOP in any state: go to IDLE, sda_out = 1, busy = 0.
- Bit counter is 3 bits, MSB first; a byte completes on the 8th SCL rise.
- RX_ADDR byte complete:
  - Address [7:1] == SLV_ADDR: go to ACK_ADDR, busy = 1.
  - Otherwise: go to IGNORE; sda_out stays 1 until the next START or STOP.
- ACK_ADDR:
  - sda_out = 0 from the SCL fall after bit 8 until the SCL fall after the 9th clock.
  - Then R/W=0 → RX_PTR.
  - R/W=1 → TX_DATA, with the MSB of reg[ptr] driven at that same fall.
- RX_PTR: the received byte [3:0] loads the pointer; bits [7:4] are ignored. Then ACK_PTR (ACK timing as above), then RX_DATA.
- RX_DATA byte complete:
  - reg[ptr] <= byte.
  - wr_stb pulses 1 cycle, with wr_addr = ptr and wr_data = byte.
  - Pointer increments, wrapping 15 → 0.
  - Then ACK_DATA, then RX_DATA again.
- TX_DATA:
  - Shift register loads reg[ptr] at the byte start; the next bit is driven on each SCL fall.
  - After the 8th bit: release SDA, pointer increments (wrapping), go to RX_MACK.
- RX_MACK (SDA sampled on the 9th SCL rise):
  - 0 (ACK): go to TX_DATA with the next byte.
  - 1 (NACK): go to IGNORE with sda_out = 1.
- Simultaneous events:
  - START or STOP takes priority over any edge-driven transition in the same cycle.
  - A wr_stb in the cycle of a STOP still completes.
- Reset mid-transfer: sda_out is released immediately (asynchronously); register contents return to 0.

Test Plan:
- Write transaction: START, 0xA0, ptr 0x03, 0xA5, 0x5A, STOP.
  - ACK (sda_out=0) on all 4 ninth clocks.
  - wr_stb twice: (3, 0xA5) then (4, 0x5A).
  - busy returns to 0 after STOP.
- Read after write: START, 0xA0, ptr 0x03, repeated START, 0xA1, read 2 bytes (ACK then NACK), STOP.
  - sda_out shifts 0xA5 then 0x5A.
  - Released after the NACK.
- Address mismatch: START, 0xA2, 0x11, STOP.
  - sda_out stays 1 throughout.
  - No wr_stb, busy stays 0.
- Pointer wrap: write ptr 0x0F with data 0x11, 0x22.
  - wr_stb at addr 15 then addr 0.
  - A subsequent read from ptr 0x0F returns 0x11, 0x22.
- Glitch rejection (FILT_LEN=3): 2-cycle low pulse on scl_in mid-byte.
  - No bit is shifted; the byte received is unaffected.
- Reset asserted while sda_out=0 during an ACK.
  - sda_out = 1 in the same cycle.
  - A read of reg 3 after a new transaction returns 0x00.
